// File: rtl/bitrev_pkg.sv
// Shared types and constants for the bit-serial bit-reversal sequencer.
package bitrev_pkg;

  // Sequencer states: waiting for a word, shifting it bit by bit, presenting it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Word mode, sampled only on the accept edge.
  localparam logic MODE_REV  = 1'b0;
  localparam logic MODE_PASS = 1'b1;

endpackage

// File: rtl/bitrev_shift_dp.sv
// Source/destination shift-register pair. src drains LSB-first into the
// bottom of dst, so after WIDTH shifts dst holds the bit-reversed word.
module bitrev_shift_dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             pass_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] dst_o
);

  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] dst_q, dst_d;

  // Register the pair; reset clears both asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
    end
  end

  // Clear beats load beats shift; a pass-load puts the word straight into dst.
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    if (clear_i) begin
      dst_d = '0;
    end else if (load_i) begin
      src_d = data_i;
      dst_d = pass_i ? data_i : '0;
    end else if (shift_i) begin
      dst_d = {dst_q[WIDTH-2:0], src_q[0]};
      src_d = src_q >> 1;
    end
  end

  assign dst_o = dst_q;

endmodule

// File: rtl/bitrev_seq.sv
// Bit-reversal sequencer: valid/ready in, one bit per cycle through the
// shift pair, valid/ready out, plus a saturating count of delivered words.
module bitrev_seq
  import bitrev_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] DONE_MAX = '1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             accept;
  logic             deliver;
  logic             shift_en;
  logic             load_pass;

  // A finished word can be swapped for a new one on the edge it is consumed.
  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready && !flush;
  assign deliver   = out_valid && out_ready;
  assign load_pass = (in_mode == MODE_PASS);
  assign done_cnt  = done_q;

  // State, bit counter and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next state: flush wins; otherwise accept, shift, or drain to IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            cnt_d   = '0;
            state_d = load_pass ? HOLD : SHIFT;
          end else if (deliver) begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = HOLD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A word handed over on a flush edge still counts: the consumer saw it.
  always_comb begin
    done_d = done_q;
    if (deliver && (done_q != DONE_MAX)) begin
      done_d = done_q + 1'b1;
    end
  end

  bitrev_shift_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush),
    .load_i  (accept),
    .pass_i  (load_pass),
    .shift_i (shift_en),
    .data_i  (in_data),
    .dst_o   (out_data)
  );

endmodule
